// File: rtl/clock_divider_bank.sv
// clock_divider_bank: N_CH programmable clock dividers sharing clk_in, divisor changes applied only at period boundaries.
// Latency: an idle channel starts one edge after its config accept; a running channel switches at its next period boundary.
// Backpressure: cfg_ready drops while the addressed channel holds an unapplied divisor; out-of-range channels accept and drop.
// Optional feature macro CLKDIV_SYNC_EN adds sync_restart, which phase-aligns every channel on one edge.
module clock_divider_bank #(
  parameter  int N_CH  = 4,
  parameter  int WIDTH = 8,
  localparam int CH_W  = $clog2(N_CH)
) (
  input  logic             clk_in,
  input  logic             rst,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync_restart,
`endif
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [WIDTH-1:0] cfg_div,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  busy
);

  // Number of encodable channel selects; entries past N_CH read as never busy.
  localparam int N_SEL = 1 << CH_W;

  logic [N_CH-1:0][WIDTH-1:0] cnt;
  logic [N_CH-1:0][WIDTH-1:0] div_act;
  logic [N_CH-1:0][WIDTH-1:0] pend;

  logic [N_CH-1:0][WIDTH-1:0] per_len;
  logic [N_CH-1:0][WIDTH-1:0] hi_len;
  logic [N_CH-1:0]            at_end;
  logic [N_CH-1:0]            wr_en;
  logic [N_CH-1:0]            next_on;
  logic [N_SEL-1:0]           busy_ext;
  logic                       restart_all;

`ifdef CLKDIV_SYNC_EN
  assign restart_all = sync_restart;
`else
  assign restart_all = 1'b0;
`endif

  // Widen busy to the full select range so out-of-range selects see a free slot.
  always_comb begin
    busy_ext           = '0;
    busy_ext[N_CH-1:0] = busy;
  end

  assign cfg_ready = !busy_ext[cfg_ch];

  // Per-channel period, high time, boundary detect and write decode.
  always_comb begin
    per_len = '0;
    hi_len  = '0;
    at_end  = '0;
    wr_en   = '0;
    next_on = '0;
    for (int i = 0; i < N_CH; i++) begin
      // D=1 cannot make a one-cycle clock, so it runs as period 2.
      per_len[i] = (div_act[i] == WIDTH'(1)) ? WIDTH'(2) : div_act[i];
      // High time is ceil(P/2): odd periods spend the extra cycle high.
      hi_len[i]  = (per_len[i] >> 1) + {{(WIDTH-1){1'b0}}, per_len[i][0]};
      // A disabled channel is permanently at a boundary.
      at_end[i]  = (div_act[i] == '0) || (cnt[i] == per_len[i] - WIDTH'(1));
      wr_en[i]   = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
      // Whether the channel runs after a restart/apply, given what gets loaded.
      next_on[i] = busy[i] ? (pend[i] != '0) : (div_act[i] != '0);
    end
  end

  // Counter, divisor apply and registered clock/tick generation for every channel.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt     <= '0;
      div_act <= '0;
      pend    <= '0;
      busy    <= '0;
      clk_out <= '0;
      tick    <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (restart_all || (busy[i] && at_end[i])) begin
          // New period: take the pending divisor if one is waiting.
          if (busy[i]) begin
            div_act[i] <= pend[i];
            busy[i]    <= 1'b0;
          end
          cnt[i]     <= '0;
          clk_out[i] <= next_on[i];
          tick[i]    <= next_on[i];
        end else if (div_act[i] == '0) begin
          cnt[i]     <= '0;
          clk_out[i] <= 1'b0;
          tick[i]    <= 1'b0;
        end else if (at_end[i]) begin
          cnt[i]     <= '0;
          clk_out[i] <= 1'b1;
          tick[i]    <= 1'b1;
        end else begin
          cnt[i]     <= cnt[i] + WIDTH'(1);
          clk_out[i] <= (cnt[i] + WIDTH'(1)) < hi_len[i];
          tick[i]    <= 1'b0;
        end
        // An accept only happens on a non-busy channel, so it never races the apply above.
        if (wr_en[i]) begin
          pend[i] <= cfg_div;
          busy[i] <= 1'b1;
        end
      end
    end
  end

endmodule
